// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index, data word and the queued write request.
// Also provides a helper that decodes a register index to a one-hot mask.
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    localparam int ARB_DEPTH = 2;

    typedef struct packed {
        regbits_t sel;
        word_t    dat;
    } wr_req_t;

    function automatic word_t reg_mask(input regbits_t r);
        word_t m;
        m    = '0;
        m[r] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/rf_write_arbiter_wr_fifo.sv
// Two-entry write-request FIFO with occupancy count.
// Also reports which registers its valid entries target.
module wr_fifo
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        push,
    input  wr_req_t     din,
    input  logic        pop,
    output logic [1:0]  count,
    output logic        full,
    output logic        empty,
    output wr_req_t     head,
    output logic [31:0] pend
);

    wr_req_t mem [ARB_DEPTH];
    logic    rptr;
    logic    wptr;

    assign full  = (count == 2'(ARB_DEPTH));
    assign empty = (count == 2'd0);
    assign head  = empty ? '0 : mem[rptr];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rptr   <= 1'b0;
            wptr   <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wptr] <= din;
                wptr      <= ~wptr;
            end
            if (pop) begin
                rptr <= ~rptr;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Only occupied slots contribute; register 0 is never reported.
    always_comb begin
        pend = '0;
        if (count != 2'd0) begin
            pend = pend | reg_mask(mem[rptr].sel);
        end
        if (count == 2'd2) begin
            pend = pend | reg_mask(mem[~rptr].sel);
        end
        pend[0] = 1'b0;
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Two-port register-file write arbiter; one write issued per cycle.
// RF_ARB_RR_EN selects round-robin, otherwise port 0 has fixed priority.
module rf_write_arbiter
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        req0_valid,
    input  logic [4:0]  req0_sel,
    input  logic [31:0] req0_dat,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [4:0]  req1_sel,
    input  logic [31:0] req1_dat,
    output logic        req1_ready,
    output logic        rf_WEN,
    output logic [4:0]  rf_wsel,
    output logic [31:0] rf_wdat,
    output logic [31:0] pending
);

    logic        push0, push1;
    logic        gnt0, gnt1;
    logic        full0, full1;
    logic        empty0, empty1;
    logic [1:0]  cnt0, cnt1;
    wr_req_t     head0, head1;
    wr_req_t     din0, din1;
    logic [31:0] pend0, pend1;

    assign req0_ready = !full0;
    assign req1_ready = !full1;

    // Writes to register 0 are accepted but dropped here.
    assign push0 = req0_valid && req0_ready && (req0_sel != 5'd0);
    assign push1 = req1_valid && req1_ready && (req1_sel != 5'd0);

    assign din0 = '{sel: req0_sel, dat: req0_dat};
    assign din1 = '{sel: req1_sel, dat: req1_dat};

    wr_fifo u_fifo0 (
        .CLK   (CLK),
        .nRST  (nRST),
        .push  (push0),
        .din   (din0),
        .pop   (gnt0),
        .count (cnt0),
        .full  (full0),
        .empty (empty0),
        .head  (head0),
        .pend  (pend0)
    );

    wr_fifo u_fifo1 (
        .CLK   (CLK),
        .nRST  (nRST),
        .push  (push1),
        .din   (din1),
        .pop   (gnt1),
        .count (cnt1),
        .full  (full1),
        .empty (empty1),
        .head  (head1),
        .pend  (pend1)
    );

`ifdef RF_ARB_RR_EN
    logic last;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            last <= 1'b1;
        end else if (gnt0) begin
            last <= 1'b0;
        end else if (gnt1) begin
            last <= 1'b1;
        end
    end

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        unique case (1'b1)
            (!empty0 && (empty1 || last)):  gnt0 = 1'b1;
            (!empty1 && (empty0 || !last)): gnt1 = 1'b1;
            default: ;
        endcase
    end
`else
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        unique case (1'b1)
            (!empty0):           gnt0 = 1'b1;
            (empty0 && !empty1): gnt1 = 1'b1;
            default: ;
        endcase
    end
`endif

    always_comb begin
        rf_WEN  = 1'b0;
        rf_wsel = '0;
        rf_wdat = '0;
        unique case (1'b1)
            gnt0: begin
                rf_WEN  = 1'b1;
                rf_wsel = head0.sel;
                rf_wdat = head0.dat;
            end
            gnt1: begin
                rf_WEN  = 1'b1;
                rf_wsel = head1.sel;
                rf_wdat = head1.dat;
            end
            default: ;
        endcase
    end

    assign pending = pend0 | pend1;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed testbench for rf_write_arbiter.
// Expected orders depend on whether RF_ARB_RR_EN is defined.
module tb_rf_write_arbiter;

    logic        CLK;
    logic        nRST;
    logic        req0_valid;
    logic [4:0]  req0_sel;
    logic [31:0] req0_dat;
    logic        req0_ready;
    logic        req1_valid;
    logic [4:0]  req1_sel;
    logic [31:0] req1_dat;
    logic        req1_ready;
    logic        rf_WEN;
    logic [4:0]  rf_wsel;
    logic [31:0] rf_wdat;
    logic [31:0] pending;

    int total;
    int bad;

    logic [4:0]  p0_sel [3];
    logic [31:0] p0_dat [3];
    logic [4:0]  p1_sel [3];
    logic [31:0] p1_dat [3];
    int          p0_n, p1_n;
    int          acc0, acc1;
    logic        r0_low, r1_low;
    logic [4:0]  iss_sel [$];
    logic [31:0] iss_dat [$];
    logic [4:0]  exp_sel [$];
    logic [31:0] exp_dat [$];

    rf_write_arbiter dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .req0_valid (req0_valid),
        .req0_sel   (req0_sel),
        .req0_dat   (req0_dat),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_sel   (req1_sel),
        .req1_dat   (req1_dat),
        .req1_ready (req1_ready),
        .rf_WEN     (rf_WEN),
        .rf_wsel    (rf_wsel),
        .rf_wdat    (rf_wdat),
        .pending    (pending)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic idle_inputs();
        req0_valid = 1'b0;
        req0_sel   = '0;
        req0_dat   = '0;
        req1_valid = 1'b0;
        req1_sel   = '0;
        req1_dat   = '0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        idle_inputs();
        nRST = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
    endtask

    // Drives the p0/p1 tables and records every issued write.
    task automatic run_streams(input int cycles);
        bit a0, a1;
        acc0   = 0;
        acc1   = 0;
        r0_low = 1'b0;
        r1_low = 1'b0;
        iss_sel.delete();
        iss_dat.delete();
        for (int c = 0; c < cycles; c++) begin
            if (rf_WEN) begin
                iss_sel.push_back(rf_wsel);
                iss_dat.push_back(rf_wdat);
            end
            if (!req0_ready) r0_low = 1'b1;
            if (!req1_ready) r1_low = 1'b1;
            req0_valid = (acc0 < p0_n);
            req0_sel   = (acc0 < p0_n) ? p0_sel[acc0] : 5'd0;
            req0_dat   = (acc0 < p0_n) ? p0_dat[acc0] : 32'd0;
            req1_valid = (acc1 < p1_n);
            req1_sel   = (acc1 < p1_n) ? p1_sel[acc1] : 5'd0;
            req1_dat   = (acc1 < p1_n) ? p1_dat[acc1] : 32'd0;
            a0 = req0_valid && req0_ready;
            a1 = req1_valid && req1_ready;
            @(posedge CLK);
            @(negedge CLK);
            if (a0) acc0++;
            if (a1) acc1++;
        end
        idle_inputs();
    endtask

    task automatic check_issues(input string name);
        total++;
        if (iss_sel.size() !== exp_sel.size()) begin
            bad++;
            $display("FAIL %s count: got %0d want %0d",
                     name, iss_sel.size(), exp_sel.size());
        end else begin
            for (int i = 0; i < exp_sel.size(); i++) begin
                total++;
                if (iss_sel[i] !== exp_sel[i] || iss_dat[i] !== exp_dat[i]) begin
                    bad++;
                    $display("FAIL %s[%0d]: got sel=%0d dat=%h want sel=%0d dat=%h",
                             name, i, iss_sel[i], iss_dat[i], exp_sel[i], exp_dat[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        nRST = 1'b0;
        #3;
        total++;
        if ({rf_WEN, rf_wsel, rf_wdat, pending, req0_ready, req1_ready} !==
            {1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL reset_during: wen=%b sel=%0d dat=%h pend=%h rdy=%b%b",
                     rf_WEN, rf_wsel, rf_wdat, pending, req0_ready, req1_ready);
        end
        do_reset();
        total++;
        if ({rf_WEN, rf_wsel, rf_wdat, pending, req0_ready, req1_ready} !==
            {1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL reset_after: wen=%b sel=%0d dat=%h pend=%h rdy=%b%b",
                     rf_WEN, rf_wsel, rf_wdat, pending, req0_ready, req1_ready);
        end
    endtask

    task automatic test_single_write();
        do_reset();
        req0_valid = 1'b1;
        req0_sel   = 5'd5;
        req0_dat   = 32'hDEADBEEF;
        @(posedge CLK);
        @(negedge CLK);
        idle_inputs();
        total++;
        if ({rf_WEN, rf_wsel, rf_wdat} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
            bad++;
            $display("FAIL single_issue: wen=%b sel=%0d dat=%h want 1/5/deadbeef",
                     rf_WEN, rf_wsel, rf_wdat);
        end
        total++;
        if (pending !== 32'h0000_0020) begin
            bad++;
            $display("FAIL single_pend: got %h want 00000020", pending);
        end
        @(posedge CLK);
        @(negedge CLK);
        total++;
        if ({rf_WEN, pending} !== {1'b0, 32'd0}) begin
            bad++;
            $display("FAIL single_drain: wen=%b pend=%h want 0/0", rf_WEN, pending);
        end
    endtask

    task automatic test_arb_order();
        do_reset();
        p0_n = 2;
        p1_n = 2;
        p0_sel[0] = 5'd1; p0_dat[0] = 32'h0000_0101;
        p0_sel[1] = 5'd2; p0_dat[1] = 32'h0000_0202;
        p1_sel[0] = 5'd3; p1_dat[0] = 32'h0000_0303;
        p1_sel[1] = 5'd4; p1_dat[1] = 32'h0000_0404;
        run_streams(10);
        exp_sel.delete();
        exp_dat.delete();
`ifdef RF_ARB_RR_EN
        exp_sel = '{5'd1, 5'd3, 5'd2, 5'd4};
        exp_dat = '{32'h101, 32'h303, 32'h202, 32'h404};
`else
        exp_sel = '{5'd1, 5'd2, 5'd3, 5'd4};
        exp_dat = '{32'h101, 32'h202, 32'h303, 32'h404};
`endif
        check_issues("arb_order");
    endtask

    task automatic test_back_to_back();
        do_reset();
        p0_n = 3;
        p1_n = 3;
        p0_sel[0] = 5'd11; p0_dat[0] = 32'hA000_0011;
        p0_sel[1] = 5'd12; p0_dat[1] = 32'hA000_0012;
        p0_sel[2] = 5'd13; p0_dat[2] = 32'hA000_0013;
        p1_sel[0] = 5'd21; p1_dat[0] = 32'hB000_0021;
        p1_sel[1] = 5'd22; p1_dat[1] = 32'hB000_0022;
        p1_sel[2] = 5'd23; p1_dat[2] = 32'hB000_0023;
        run_streams(14);
        total++;
        if (acc0 !== 3 || acc1 !== 3) begin
            bad++;
            $display("FAIL b2b_accepts: got %0d/%0d want 3/3", acc0, acc1);
        end
        total++;
        if (r1_low !== 1'b1) begin
            bad++;
            $display("FAIL b2b_ready1_low: got %b want 1", r1_low);
        end
        exp_sel.delete();
        exp_dat.delete();
`ifdef RF_ARB_RR_EN
        total++;
        if (r0_low !== 1'b1) begin
            bad++;
            $display("FAIL b2b_ready0_low: got %b want 1", r0_low);
        end
        exp_sel = '{5'd11, 5'd21, 5'd12, 5'd22, 5'd13, 5'd23};
        exp_dat = '{32'hA000_0011, 32'hB000_0021, 32'hA000_0012,
                    32'hB000_0022, 32'hA000_0013, 32'hB000_0023};
`else
        total++;
        if (r0_low !== 1'b0) begin
            bad++;
            $display("FAIL b2b_ready0_high: got low=%b want 0", r0_low);
        end
        exp_sel = '{5'd11, 5'd12, 5'd13, 5'd21, 5'd22, 5'd23};
        exp_dat = '{32'hA000_0011, 32'hA000_0012, 32'hA000_0013,
                    32'hB000_0021, 32'hB000_0022, 32'hB000_0023};
`endif
        check_issues("b2b_order");
        total++;
        if ({req0_ready, req1_ready, pending} !== {1'b1, 1'b1, 32'd0}) begin
            bad++;
            $display("FAIL b2b_idle: rdy=%b%b pend=%h want 11/0",
                     req0_ready, req1_ready, pending);
        end
    endtask

    task automatic test_sel_zero();
        bit seen;
        do_reset();
        req1_valid = 1'b1;
        req1_sel   = 5'd0;
        req1_dat   = 32'h0000_1234;
        seen = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        idle_inputs();
        total++;
        if ({rf_WEN, pending, req1_ready} !== {1'b0, 32'd0, 1'b1}) begin
            bad++;
            $display("FAIL sel0_next: wen=%b pend=%h rdy1=%b want 0/0/1",
                     rf_WEN, pending, req1_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            if (rf_WEN) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL sel0_no_write: got wen seen=%b want 0", seen);
        end
    endtask

    task automatic test_reset_flush();
        bit seen;
        do_reset();
        req0_valid = 1'b1;
        req0_sel   = 5'd9;
        req0_dat   = 32'h9999_9999;
        req1_valid = 1'b1;
        req1_sel   = 5'd10;
        req1_dat   = 32'h1010_1010;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            @(negedge CLK);
        end
        total++;
        if (pending === 32'd0) begin
            bad++;
            $display("FAIL flush_pre: got pend=%h want nonzero", pending);
        end
        #2;
        nRST = 1'b0;
        #1;
        total++;
        if ({rf_WEN, rf_wsel, rf_wdat, pending, req0_ready, req1_ready} !==
            {1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL flush_now: wen=%b sel=%0d dat=%h pend=%h rdy=%b%b",
                     rf_WEN, rf_wsel, rf_wdat, pending, req0_ready, req1_ready);
        end
        idle_inputs();
        @(negedge CLK);
        nRST = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (rf_WEN || pending != 32'd0) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL flush_lost: got activity=%b want 0", seen);
        end
    endtask

    task automatic test_same_reg();
        do_reset();
        req0_valid = 1'b1;
        req0_sel   = 5'd7;
        req0_dat   = 32'h0000_000A;
        req1_valid = 1'b1;
        req1_sel   = 5'd7;
        req1_dat   = 32'h0000_000B;
        @(posedge CLK);
        @(negedge CLK);
        idle_inputs();
        total++;
        if ({rf_WEN, rf_wsel, rf_wdat, pending} !==
            {1'b1, 5'd7, 32'hA, 32'h80}) begin
            bad++;
            $display("FAIL same_first: wen=%b sel=%0d dat=%h pend=%h want 1/7/a/80",
                     rf_WEN, rf_wsel, rf_wdat, pending);
        end
        @(posedge CLK);
        @(negedge CLK);
        total++;
        if ({rf_WEN, rf_wsel, rf_wdat, pending} !==
            {1'b1, 5'd7, 32'hB, 32'h80}) begin
            bad++;
            $display("FAIL same_second: wen=%b sel=%0d dat=%h pend=%h want 1/7/b/80",
                     rf_WEN, rf_wsel, rf_wdat, pending);
        end
        @(posedge CLK);
        @(negedge CLK);
        total++;
        if ({rf_WEN, pending} !== {1'b0, 32'd0}) begin
            bad++;
            $display("FAIL same_done: wen=%b pend=%h want 0/0", rf_WEN, pending);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        nRST  = 1'b0;
        idle_inputs();
        test_reset();
        test_single_write();
        test_arb_order();
        test_back_to_back();
        test_sel_zero();
        test_reset_flush();
        test_same_reg();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 The block SHALL have input CLK, 1 bit: clock; all state updates on the rising edge.
REQ-002 The block SHALL have input nRST, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have inputs req0_valid (1), req0_sel (5) and req0_dat (32): port 0 write request, register index and data.
REQ-004 The block SHALL have output req0_ready, 1 bit: port 0 can accept a request.
REQ-005 The block SHALL have inputs req1_valid (1), req1_sel (5) and req1_dat (32), and output req1_ready (1): port 1, same semantics as port 0.
REQ-006 The block SHALL have outputs rf_WEN (1), rf_wsel (5) and rf_wdat (32): single register-file write port.
REQ-007 The block SHALL have output pending, 32 bits: bit r is 1 when any queued entry targets register r.

Function
REQ-008 The block SHALL give each port a private 2-entry FIFO with an occupancy counter (0..2).
REQ-009 reqN_ready SHALL be 1 iff FIFO N count < 2; ready SHALL NOT depend on a same-cycle pop.
REQ-010 A request SHALL be accepted at a rising edge where reqN_valid=1 and reqN_ready=1.
REQ-011 An accepted request with sel=0 SHALL be consumed and discarded: no enqueue, no rf_WEN, no pending bit.
REQ-012 Each cycle with at least one FIFO non-empty, the block SHALL grant exactly one FIFO head.
REQ-013 When granting, rf_WEN=1 and rf_wsel/rf_wdat SHALL equal the granted head, combinationally; the head pops at the next edge.
REQ-014 With no FIFO non-empty, rf_WEN SHALL be 0 and rf_wsel/rf_wdat SHALL be 0.
REQ-015 Minimum latency SHALL be: accepted at edge N, driven on rf_* during cycle N..N+1, written into the register file at edge N+1.
REQ-016 A simultaneous push and pop on the same FIFO SHALL leave the count unchanged and preserve order.
REQ-017 Per-port order SHALL be preserved; cross-port order SHALL follow grant order only.
REQ-018 Same-register writes from both ports SHALL both be issued, the later grant winning in the register file.
REQ-019 pending SHALL be computed combinationally from valid FIFO entries; bit 0 SHALL always be 0.

Reset
REQ-020 nRST=0 SHALL asynchronously clear both FIFOs, counts and the grant pointer.
REQ-021 During and after reset: rf_WEN=0, rf_wsel=0, rf_wdat=0, pending=0, req0_ready=1, req1_ready=1.
REQ-022 Queued writes present at reset assertion SHALL be lost, never issued.

Configuration
REQ-023 With RF_ARB_RR_EN defined: round-robin arbitration; a last-grant register (reset value 1) gives priority to the port not granted last; a single requester is always granted.
REQ-024 With RF_ARB_RR_EN undefined: fixed priority with port 0 over port 1 and no last-grant register; port 1 may starve.

Structure
REQ-025 cpu_types_pkg SHALL hold word_t, regbits_t, ARB_DEPTH=2 and a new packed struct wr_req_t {regbits_t sel; word_t dat;}.
REQ-026 Sub-module wr_fifo (2-entry FIFO of wr_req_t with count, full, empty and head outputs) SHALL be instantiated once per port.

Verification
REQ-027 Reset, then port 0 sends sel=5, dat=0xDEADBEEF -> next cycle rf_WEN=1, rf_wsel=5, rf_wdat=0xDEADBEEF, pending[5]=1; the cycle after, rf_WEN=0, pending=0.
REQ-028 Both ports valid for 4 cycles (p0 sels 1,2; p1 sels 3,4) with RF_ARB_RR_EN -> issue order 1,3,2,4; without it -> 1,2,3,4.
REQ-029 Port 0 pushes 3 requests back-to-back while port 1 holds priority -> req0_ready=0 after 2 accepted; the third is accepted only after count drops; no loss, no duplicates.
REQ-030 Port 1 sends sel=0, dat=0x1234 -> no rf_WEN pulse, pending stays 0, req1_ready stays 1.
REQ-031 Both FIFOs full, nRST pulsed low mid-cycle -> rf_WEN=0 and pending=0 immediately; none of the queued writes appear after release.
REQ-032 Both ports target sel=7 (p0 0xA, p1 0xB) with p0 granted first -> rf_wdat 0xA then 0xB; pending[7] clears only after the second write.
